// File: rtl/rx_frame_sync_pkg.sv
// Shared frame-format constants and FSM encoding for the PSK receive deframer.
// The Tx framer imports the same values so both ends agree on the frame layout.
package rx_frame_sync_pkg;

  localparam int unsigned SYNC_LEN_DEFAULT    = 32;
  localparam logic [31:0] SYNC_WORD_DEFAULT   = 32'h1ACFFC1D;
  localparam int unsigned SYNC_TOL_DEFAULT    = 2;
  localparam int unsigned FRAME_BYTES_DEFAULT = 4;
  localparam int unsigned MISS_MAX_DEFAULT    = 3;

  // HUNT searches every bit position, PAYLOAD deserializes, CHECK verifies the next sync
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } frame_state_e;

endpackage

// File: rtl/rx_frame_sync_correlator.sv
// Sync word correlator: Hamming distance of the candidate window against the
// sync pattern and its bitwise inverse, each compared against the tolerance.
module rx_frame_sync_correlator
  import rx_frame_sync_pkg::*;
#(
  parameter int unsigned SYNC_LEN  = SYNC_LEN_DEFAULT,
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned SYNC_TOL  = SYNC_TOL_DEFAULT
) (
  input  logic [SYNC_LEN-1:0] sr_next,
  output logic                hit_n,
  output logic                hit_i
);

  localparam int unsigned        D_W     = $clog2(SYNC_LEN + 1);
  localparam logic [SYNC_LEN-1:0] PATTERN = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [D_W-1:0]      TOL     = D_W'(SYNC_TOL);

  logic [SYNC_LEN-1:0] diff_n;
  logic [SYNC_LEN-1:0] diff_i;
  logic [D_W-1:0]      dist_n;
  logic [D_W-1:0]      dist_i;

  // Popcount both XOR differences; a window within tolerance of either polarity is a hit
  always_comb begin
    diff_n = sr_next ^ PATTERN;
    diff_i = sr_next ^ ~PATTERN;
    dist_n = '0;
    dist_i = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      dist_n = dist_n + D_W'(diff_n[i]);
      dist_i = dist_i + D_W'(diff_i[i]);
    end
    hit_n = (dist_n <= TOL);
    hit_i = (dist_i <= TOL);
  end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchronizer / deframer for the PSK receiver hard-decision bit stream.
// Hunts for the sync word in either polarity, then deserializes fixed-length
// payloads into a byte stream with a flywheel that tolerates a few missed syncs.
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter int unsigned SYNC_LEN    = SYNC_LEN_DEFAULT,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int unsigned SYNC_TOL    = SYNC_TOL_DEFAULT,
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int unsigned MISS_MAX    = MISS_MAX_DEFAULT
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  output logic        data_tlast,
  output logic        data_tuser,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [15:0] sync_miss_cnt
);

  localparam int unsigned PAY_BITS = FRAME_BYTES * 8;
  localparam int unsigned CNT_W    = $clog2(PAY_BITS + SYNC_LEN + 1);
  localparam int unsigned MISS_W   = $clog2(MISS_MAX + 1);

  localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(PAY_BITS - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  // Only the older SYNC_LEN-1 window bits and 7 byte bits need storage: the
  // newest bit always comes straight from bit_in when the window is evaluated.
  frame_state_e        state_q, state_d;
  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [6:0]          byte_q, byte_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                inv_q, inv_d;
  logic                locked_q, locked_d;
  logic [7:0]          tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                tuser_q, tuser_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         sync_miss_cnt_q, sync_miss_cnt_d;

  logic [SYNC_LEN-1:0] sr_next;
  logic [7:0]          byte_next;
  logic                hit_n;
  logic                hit_i;

  rx_frame_sync_correlator #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD),
    .SYNC_TOL  (SYNC_TOL)
  ) u_correlator (
    .sr_next (sr_next),
    .hit_n   (hit_n),
    .hit_i   (hit_i)
  );

  // Next-state logic: everything advances only on a bit_valid strobe
  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    byte_d          = byte_q;
    bit_cnt_d       = bit_cnt_q;
    miss_d          = miss_q;
    inv_d           = inv_q;
    locked_d        = locked_q;
    tdata_d         = tdata_q;
    tvalid_d        = 1'b0;
    tlast_d         = 1'b0;
    tuser_d         = tuser_q;
    frame_cnt_d     = frame_cnt_q;
    sync_miss_cnt_d = sync_miss_cnt_q;

    sr_next   = {sr_q, bit_in};
    byte_next = {byte_q, bit_in ^ inv_q};

    if (bit_valid) begin
      sr_d = sr_next[SYNC_LEN-2:0];
      case (state_q)
        ST_HUNT: begin
          if (hit_n || hit_i) begin
            state_d   = ST_PAYLOAD;
            inv_d     = !hit_n;
            locked_d  = 1'b1;
            miss_d    = '0;
            bit_cnt_d = '0;
          end
        end

        ST_PAYLOAD: begin
          byte_d    = byte_next[6:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            tdata_d  = byte_next;
            tuser_d  = inv_q;
            tvalid_d = 1'b1;
            tlast_d  = (bit_cnt_q == PAY_LAST);
          end
          if (bit_cnt_q == PAY_LAST) begin
            state_d     = ST_CHECK;
            bit_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end

        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == SYNC_LAST) begin
            bit_cnt_d = '0;
            if (hit_n || hit_i) begin
              miss_d  = '0;
              inv_d   = !hit_n;
              state_d = ST_PAYLOAD;
            end else begin
              miss_d = miss_q + 1'b1;
              if (sync_miss_cnt_q != 16'hFFFF) begin
                sync_miss_cnt_d = sync_miss_cnt_q + 16'd1;
              end
              if (miss_q == MISS_LAST) begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // State, deserializer, counters and registered stream outputs
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state_q         <= ST_HUNT;
      sr_q            <= '0;
      byte_q          <= '0;
      bit_cnt_q       <= '0;
      miss_q          <= '0;
      inv_q           <= 1'b0;
      locked_q        <= 1'b0;
      tdata_q         <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tuser_q         <= 1'b0;
      frame_cnt_q     <= '0;
      sync_miss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      sr_q            <= sr_d;
      byte_q          <= byte_d;
      bit_cnt_q       <= bit_cnt_d;
      miss_q          <= miss_d;
      inv_q           <= inv_d;
      locked_q        <= locked_d;
      tdata_q         <= tdata_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      tuser_q         <= tuser_d;
      frame_cnt_q     <= frame_cnt_d;
      sync_miss_cnt_q <= sync_miss_cnt_d;
    end
  end

  assign data_tdata    = tdata_q;
  assign data_tvalid   = tvalid_q;
  assign data_tlast    = tlast_q;
  assign data_tuser    = tuser_q;
  assign locked        = locked_q;
  assign frame_cnt     = frame_cnt_q;
  assign sync_miss_cnt = sync_miss_cnt_q;

endmodule
